// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-control and result bundle between the op sequencer and its neighbours.
// master = sequencer side, slave = upstream/ALU/consumer side.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OPW-1:0]   cmd_op;
    logic             cmd_keep_a;

    logic [WIDTH-1:0] alu_din;
    logic             alu_ldA;
    logic             alu_ldB;
    logic [OPW-1:0]   alu_control;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout;
    logic             alu_zero;
    logic             alu_ovf;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
    logic             res_zero;
    logic             res_ovf;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_keep_a,
        input  alu_out, alu_cout, alu_zero, alu_ovf, res_ready,
        output cmd_ready, alu_din, alu_ldA, alu_ldB, alu_control,
        output res_valid, res_data, res_cout, res_zero, res_ovf
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_keep_a,
        output alu_out, alu_cout, alu_zero, alu_ovf, res_ready,
        input  cmd_ready, alu_din, alu_ldA, alu_ldB, alu_control,
        input  res_valid, res_data, res_cout, res_zero, res_ovf
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU op per command: load A (skippable), load B, exec, hold result until taken.
// Result 3 cycles after accept (2 with keep_a); no new command accepted until the result is consumed.
module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_op_sequencer_if.master   bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] b_q;
    logic             a_loaded;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            b_q             <= '0;
            a_loaded        <= 1'b0;
            bus.cmd_ready   <= 1'b1;
            bus.alu_din     <= '0;
            bus.alu_ldA     <= 1'b0;
            bus.alu_ldB     <= 1'b0;
            bus.alu_control <= '0;
            bus.res_valid   <= 1'b0;
            bus.res_data    <= '0;
            bus.res_cout    <= 1'b0;
            bus.res_zero    <= 1'b0;
            bus.res_ovf     <= 1'b0;
            busy            <= 1'b0;
            op_count        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        b_q             <= bus.cmd_b;
                        bus.alu_control <= bus.cmd_op;
                        bus.cmd_ready   <= 1'b0;
                        busy            <= 1'b1;
                        // keep_a is only honoured once the ALU's A register holds a known value
                        if (bus.cmd_keep_a && a_loaded) begin
                            state       <= LOAD_B;
                            bus.alu_din <= bus.cmd_b;
                            bus.alu_ldB <= 1'b1;
                        end else begin
                            state       <= LOAD_A;
                            bus.alu_din <= bus.cmd_a;
                            bus.alu_ldA <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    state       <= LOAD_B;
                    a_loaded    <= 1'b1;
                    bus.alu_din <= b_q;
                    bus.alu_ldA <= 1'b0;
                    bus.alu_ldB <= 1'b1;
                end
                LOAD_B: begin
                    state       <= EXEC;
                    bus.alu_din <= '0;
                    bus.alu_ldB <= 1'b0;
                end
                EXEC: begin
                    state         <= DONE;
                    bus.res_valid <= 1'b1;
                    bus.res_data  <= bus.alu_out;
                    bus.res_cout  <= bus.alu_cout;
                    bus.res_zero  <= bus.alu_zero;
                    bus.res_ovf   <= bus.alu_ovf;
                    op_count      <= op_count + 1'b1;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state         <= IDLE;
                        bus.res_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.alu_din   <= '0;
                    bus.alu_ldA   <= 1'b0;
                    bus.alu_ldB   <= 1'b0;
                    bus.res_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + randomized bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
// Expected results come from an operand-level reference model tracking the last loaded A.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;

    alu_op_sequencer_if #(.WIDTH(4), .OPW(3)) bus ();

    alu_op_sequencer #(.WIDTH(4), .OPW(3), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    // Reference ALU semantics: result {ovf, zero, cout, out[3:0]} from plain integer arithmetic.
    function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int sa, sb, r;
        logic [3:0] o;
        logic c, v;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            3'd0: begin r = int'(a) + int'(b); o = r[3:0]; c = (r > 15); v = (sa + sb > 7) || (sa + sb < -8); end
            3'd1: begin r = int'(a) - int'(b); o = r[3:0]; c = (a >= b); v = (sa - sb > 7) || (sa - sb < -8); end
            3'd2: o = a & b;
            3'd3: o = a | b;
            3'd4: o = a ^ b;
            3'd5: o = ~(a | b);
            3'd6: begin o = {a[2:0], 1'b0}; c = a[3]; end
            default: begin o = {1'b0, a[3:1]}; c = a[0]; end
        endcase
        return {v, (o == 4'd0), c, o};
    endfunction

    // Behavioural ALU: operand registers load on the strobes, result is combinational.
    logic [3:0] ra = 4'd0, rb = 4'd0;
    logic [6:0] alu_res;
    always @(posedge clk) begin
        if (bus.alu_ldA) ra <= bus.alu_din;
        if (bus.alu_ldB) rb <= bus.alu_din;
    end
    assign alu_res      = alu_ref(ra, rb, bus.alu_control);
    assign bus.alu_out  = alu_res[3:0];
    assign bus.alu_cout = alu_res[4];
    assign bus.alu_zero = alu_res[5];
    assign bus.alu_ovf  = alu_res[6];

    // Reference-model state
    logic [3:0] model_a        = 4'd0;
    bit         model_a_loaded = 1'b0;
    int         exp_cnt        = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", {7'd0, bus.cmd_ready}, 8'd1);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          input bit keep, input int hold, input bit pulse);
        bit         eff_keep;
        logic [3:0] ea;
        logic [6:0] exp;
        eff_keep = keep && model_a_loaded;
        ea       = eff_keep ? model_a : a;
        exp      = alu_ref(ea, b, op);
        wait_ready();
        bus.cmd_valid  = 1'b1;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_op     = op;
        bus.cmd_keep_a = keep;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 4'($urandom);
        bus.cmd_b     = 4'($urandom);
        chk("busy_after_accept", {7'd0, busy}, 8'd1);
        chk("cmd_ready_after_accept", {7'd0, bus.cmd_ready}, 8'd0);
        if (!eff_keep) begin
            chk("ldA_pulse", {6'd0, bus.alu_ldA, bus.alu_ldB}, 8'b10);
            chk("din_a", {4'd0, bus.alu_din}, {4'd0, a});
            @(negedge clk);
        end
        chk("ldB_pulse", {6'd0, bus.alu_ldA, bus.alu_ldB}, 8'b01);
        chk("din_b", {4'd0, bus.alu_din}, {4'd0, b});
        chk("control", {5'd0, bus.alu_control}, {5'd0, op});
        @(negedge clk);
        chk("exec_idle_bus", {2'd0, bus.alu_ldA, bus.alu_ldB, bus.alu_din}, 8'd0);
        chk("exec_no_valid", {7'd0, bus.res_valid}, 8'd0);
        @(negedge clk);
        model_a        = ea;
        model_a_loaded = 1'b1;
        exp_cnt        = (exp_cnt + 1) % 256;
        chk("res_valid", {7'd0, bus.res_valid}, 8'd1);
        chk("res_data", {4'd0, bus.res_data}, {4'd0, exp[3:0]});
        chk("res_flags", {5'd0, bus.res_ovf, bus.res_zero, bus.res_cout}, {5'd0, exp[6:4]});
        chk("op_count", op_count, 8'(exp_cnt));
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = pulse && (i == 0);
            @(negedge clk);
            chk("hold_valid", {7'd0, bus.res_valid}, 8'd1);
            chk("hold_data", {1'b0, bus.res_ovf, bus.res_zero, bus.res_cout, bus.res_data}, {1'b0, exp});
            chk("hold_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("post_hs_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("post_hs_ready", {6'd0, bus.cmd_ready, busy}, 8'b10);
        chk("post_hs_retain", {4'd0, bus.res_data}, {4'd0, exp[3:0]});
        chk("post_hs_count", op_count, 8'(exp_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_a      = 4'd0;
        bus.cmd_b      = 4'd0;
        bus.cmd_op     = 3'd0;
        bus.cmd_keep_a = 1'b0;
        bus.res_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready_busy", {6'd0, bus.cmd_ready, busy}, 8'b10);
        chk("rst_strobes_din", {2'd0, bus.alu_ldA, bus.alu_ldB, bus.alu_din}, 8'd0);
        chk("rst_control", {5'd0, bus.alu_control}, 8'd0);
        chk("rst_res", {1'b0, bus.res_valid, bus.res_ovf, bus.res_zero, bus.res_data}, 8'd0);
        chk("rst_cout_count", {7'd0, bus.res_cout} | op_count, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed ops from the test plan
        run_op(4'b0101, 4'b0011, 3'd0, 1'b0, 0, 1'b0);   // ADD -> 1000, ovf
        run_op(4'b0011, 4'b0011, 3'd1, 1'b0, 0, 1'b0);   // SUB -> 0000, zero, cout
        run_op(4'b0110, 4'b0011, 3'd2, 1'b0, 0, 1'b0);   // AND -> 0010
        run_op(4'b0000, 4'b1100, 3'd3, 1'b1, 0, 1'b0);   // OR with kept A -> 1110
        run_op(4'b1001, 4'b0111, 3'd4, 1'b0, 6, 1'b1);   // backpressure with stray cmd_valid
        @(negedge clk);
        chk("stray_cmd_ignored", {7'd0, busy}, 8'd0);

        // Reset while in LOAD_B, then keep_a must still load A
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 4'b1001;
        bus.cmd_b     = 4'b0110;
        bus.cmd_op    = 3'd0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("pre_rst_ldA", {7'd0, bus.alu_ldA}, 8'd1);
        @(negedge clk);
        chk("pre_rst_ldB", {7'd0, bus.alu_ldB}, 8'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_ldB", {7'd0, bus.alu_ldB}, 8'd0);
        chk("rst_mid_state", {6'd0, bus.cmd_ready, busy}, 8'b10);
        chk("rst_mid_res", {7'd0, bus.res_valid}, 8'd0);
        chk("rst_mid_count", op_count, 8'd0);
        @(negedge clk);
        rst            = 1'b0;
        model_a_loaded = 1'b0;
        exp_cnt        = 0;
        @(negedge clk);
        run_op(4'b0011, 4'b0001, 3'd0, 1'b1, 0, 1'b0);   // keep_a ignored: A reloaded

        // Randomized ops
        for (int n = 0; n < 40; n++) begin
            run_op(4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Counter wrap: 256 LLS ops from a clean count
        rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        model_a_loaded = 1'b0;
        exp_cnt        = 0;
        @(negedge clk);
        for (int n = 0; n < 256; n++) begin
            run_op(4'b0001, 4'b0001, 3'd6, 1'b0, 0, 1'b0);
        end
        chk("wrap_zero", op_count, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
